dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port DataMemory (clk, addr, data_in, data_out, we).
- Port 0 is the CPU load/store stage; port 1 is the debug/loader port used to preload or inspect memory.
- Latches one request at a time, drives the memory for one cycle and returns read data with a one-cycle ack.
- Round-robin between ports when both request.

---
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port data memory.
// One transaction in flight: IDLE -> ISSUE (memory driven) -> RESP (ack), with back-to-back hand-off.

module dmem_arb_port #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] rdata
);
  // Read data holds until the next read completes on this port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rdata <= '0;
    else if (cap) rdata <= din;
  end
endmodule

module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam int NUM_PORTS = 2;

  state_t                           state, state_nxt;
  req_t   [NUM_PORTS-1:0]           port_req;
  req_t                             lat, lat_nxt;
  logic   [NUM_PORTS-1:0]           req, cap;
  logic   [NUM_PORTS-1:0][DATA_W-1:0] rdata;
  logic                             last, last_nxt, owner_nxt;
  logic                             grant, win;

  assign req         = {req1, req0};
  assign port_req[0] = {we0, addr0, wdata0};
  assign port_req[1] = {we1, addr1, wdata1};

  // In RESP the served port is masked, so the other port always gets its turn.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    owner_nxt = owner;
    lat_nxt   = lat;
    grant     = 1'b0;
    win       = owner;
    case (state)
      IDLE: begin
        if (|req) begin
          grant = 1'b1;
          win   = (&req) ? ~last : req[1];
        end
      end
      ISSUE: begin
        last_nxt  = owner;
        state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
        if (req[~owner]) begin
          grant = 1'b1;
          win   = ~owner;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (grant) begin
      state_nxt = ISSUE;
      owner_nxt = win;
      lat_nxt   = port_req[win];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      owner <= 1'b0;
      lat   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      owner <= owner_nxt;
      lat   <= lat_nxt;
    end
  end

  // Memory is only written in ISSUE; reset drops mem_we combinationally via state.
  assign mem_addr  = lat.addr;
  assign mem_wdata = lat.wdata;
  assign mem_we    = (state == ISSUE) && lat.we;
  assign busy      = (state != IDLE);
  assign ack0      = (state == RESP) && !owner;
  assign ack1      = (state == RESP) &&  owner;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign cap[i] = (state == ISSUE) && !lat.we && (owner == 1'(i));
    dmem_arb_port #(.DATA_W(DATA_W)) u_port (
      .clk   (clk),
      .rst_n (rst_n),
      .cap   (cap[i]),
      .din   (mem_rdata),
      .rdata (rdata[i])
    );
  end

  assign rdata0 = rdata[0];
  assign rdata1 = rdata[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory behind it.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk, rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
  logic          ack0, ack1, mem_we, busy, owner;

  int ncmp = 0;
  int nfail = 0;

  logic [DW-1:0] mem [0:255];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output logic acked, output logic [DW-1:0] rd);
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    step();
    step();
    acked = (p == 0) ? ack0 : ack1;
    rd    = (p == 0) ? rdata0 : rdata1;
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  logic          acked;
  logic [DW-1:0] rd;

  initial begin
    rst_n = 1'b0; req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_owner", owner, 0);
    rst_n = 1'b1;
    step();

    // Preload through the debug port
    access(1, 1'b1, 8'd0, 32'h5A, acked, rd); chk("pre0_ack", acked, 1);
    access(1, 1'b1, 8'd1, 32'h11, acked, rd); chk("pre1_ack", acked, 1);
    access(1, 1'b1, 8'd3, 32'h33, acked, rd); chk("pre3_ack", acked, 1);

    // Port 0 write addr 2 = 10
    req0 = 1; we0 = 1; addr0 = 8'd2; wdata0 = 32'd10;
    step();
    chk("w0_issue_we", mem_we, 1);
    chk("w0_issue_addr", mem_addr, 2);
    chk("w0_issue_wdata", mem_wdata, 10);
    chk("w0_issue_ack0", ack0, 0);
    chk("w0_issue_owner", owner, 0);
    step();
    chk("w0_resp_ack0", ack0, 1);
    chk("w0_resp_ack1", ack1, 0);
    chk("w0_resp_we", mem_we, 0);
    req0 = 0;
    step();
    chk("w0_idle_ack0", ack0, 0);
    chk("w0_idle_busy", busy, 0);
    chk("w0_idle_we", mem_we, 0);

    // Port 0 read addr 2
    req0 = 1; we0 = 0; addr0 = 8'd2;
    step();
    chk("r0_issue_we", mem_we, 0);
    chk("r0_issue_busy", busy, 1);
    step();
    chk("r0_ack0", ack0, 1);
    chk("r0_rdata0", rdata0, 10);
    chk("r0_resp_we", mem_we, 0);
    req0 = 0;
    step();

    // Reset, then simultaneous reads: port 0 first, port 1 back-to-back
    rst_n = 0; step(); rst_n = 1; step();
    req0 = 1; we0 = 0; addr0 = 8'd1;
    req1 = 1; we1 = 0; addr1 = 8'd3;
    step();
    chk("tie_owner", owner, 0);
    chk("tie_addr", mem_addr, 1);
    step();
    chk("tie_ack0", ack0, 1);
    chk("tie_ack1a", ack1, 0);
    chk("tie_rdata0", rdata0, 32'h11);
    req0 = 0;
    step();
    chk("tie_owner1", owner, 1);
    chk("tie_addr1", mem_addr, 3);
    chk("tie_busy", busy, 1);
    chk("tie_noack", ack0 | ack1, 0);
    step();
    chk("tie_ack1", ack1, 1);
    chk("tie_rdata1", rdata1, 32'h33);
    req1 = 0;
    step();
    chk("tie_idle", busy, 0);

    // Both hold req: strict alternation, ack every 2 cycles
    req0 = 1; we0 = 0; addr0 = 8'd1;
    req1 = 1; we1 = 0; addr1 = 8'd3;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c % 2 == 0) begin
        chk($sformatf("rr_ack0_c%0d", c), ack0, ((c / 2) % 2 == 1) ? 1 : 0);
        chk($sformatf("rr_ack1_c%0d", c), ack1, ((c / 2) % 2 == 0) ? 1 : 0);
      end else begin
        chk($sformatf("rr_noack_c%0d", c), ack0 | ack1, 0);
      end
    end
    chk("rr_rdata0", rdata0, 32'h11);
    chk("rr_rdata1", rdata1, 32'h33);
    req0 = 0; req1 = 0;
    step();
    chk("rr_idle", busy, 0);

    // Port 1 write with request fields changed during ISSUE
    req1 = 1; we1 = 1; addr1 = 8'd3; wdata1 = 32'hDEAD;
    step();
    addr1 = 8'd0; wdata1 = 32'hBEEF;
    chk("chg_we", mem_we, 1);
    chk("chg_addr", mem_addr, 3);
    chk("chg_wdata", mem_wdata, 32'hDEAD);
    step();
    chk("chg_ack1", ack1, 1);
    req1 = 0;
    step();
    access(1, 1'b0, 8'd3, 32'h0, acked, rd);
    chk("chg_rd3_ack", acked, 1);
    chk("chg_rd3", rd, 32'hDEAD);
    access(0, 1'b0, 8'd0, 32'h0, acked, rd);
    chk("chg_rd0", rd, 32'h5A);

    // Reset asserted mid-ISSUE aborts the write
    req0 = 1; we0 = 1; addr0 = 8'd1; wdata0 = 32'h99;
    step();
    chk("abort_we_pre", mem_we, 1);
    #2;
    rst_n = 0;
    #1;
    chk("abort_we", mem_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack0", ack0, 0);
    req0 = 0;
    step();
    chk("abort_noack", ack0, 0);
    rst_n = 1;
    step();
    chk("abort_idle_ack", ack0 | ack1, 0);
    access(0, 1'b0, 8'd1, 32'h0, acked, rd);
    chk("abort_rd_ack", acked, 1);
    chk("abort_rd", rd, 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
